// File: rtl/bcd_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_tick_counter
//  Description : Prescaled multi-digit BCD up/down counter with a run/hold
//                toggle driven by a raw push-button, plus tick and wrap
//                strobes for the seven-segment display stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_tick_counter #(
  parameter int PRESCALE    = 10_000_000,
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  BTN,
  input  logic                  DIR,
  input  logic                  CLR,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  TICK,
  output logic                  WRAP,
  output logic                  RUNNING
);

  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_prev_q;
  logic                   btn_rise;

  state_t                 state_q, state_d;

  logic [PW-1:0]          pre_q, pre_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   tick_q, tick_d;
  logic                   wrap_q, wrap_d;

  logic [4*DIGITS-1:0]    bcd_step;
  logic                   step_carry;
  logic                   carry;
  logic [3:0]             digit;

  // Button synchroniser chain and previous-level register for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q     <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], BTN};
      btn_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign btn_rise = sync_q[SYNC_STAGES-1] & ~btn_prev_q;

  // Run/hold state register; reset lands in RUN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Each synchronised button press flips RUN <-> HOLD; CLR leaves it alone
  always_comb begin
    state_d = state_q;
    if (btn_rise) begin
      state_d = (state_q == S_RUN) ? S_HOLD : S_RUN;
    end
  end

  // Stepped digit value: carry/borrow ripples through all digits in one cycle
  always_comb begin
    carry    = 1'b1;
    digit    = '0;
    bcd_step = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd_q[4*i +: 4];
      if (carry) begin
        if (DIR) begin
          if (digit >= 4'd9) begin
            digit = 4'd0;
          end else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0 || digit > 4'd9) begin
            digit = 4'd9;
          end else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      bcd_step[4*i +: 4] = digit;
    end
    step_carry = carry;
  end

  // Prescaler and step selection; clear overrides a coincident step
  always_comb begin
    pre_d  = pre_q;
    bcd_d  = bcd_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (CLR) begin
      pre_d = '0;
      bcd_d = '0;
    end else if (state_q == S_RUN) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        bcd_d  = bcd_step;
        tick_d = 1'b1;
        wrap_d = step_carry;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Datapath registers; all outputs come straight from flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q  <= '0;
      bcd_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      bcd_q  <= bcd_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign BCD     = bcd_q;
  assign TICK    = tick_q;
  assign WRAP    = wrap_q;
  assign RUNNING = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_bcd_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_tick_counter
//  Description : Self-checking bench for bcd_tick_counter with a cycle-level
//                behavioural model plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_tick_counter;

  localparam int P    = 4;
  localparam int D    = 2;
  localparam int S    = 2;
  localparam int MAXV = 99;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn   = 1'b0;
  logic         dir   = 1'b1;
  logic         clr   = 1'b0;
  logic [4*D-1:0] bcd;
  logic         tick;
  logic         wrap;
  logic         running;

  int n_cmp  = 0;
  int n_fail = 0;

  bcd_tick_counter #(
    .PRESCALE   (P),
    .DIGITS     (D),
    .SYNC_STAGES(S)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .BTN    (btn),
    .DIR    (dir),
    .CLR    (clr),
    .BCD    (bcd),
    .TICK   (tick),
    .WRAP   (wrap),
    .RUNNING(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    int x;
    logic [4*D-1:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Behavioural model: integer count, integer phase, button sample history
  int           m_count;
  int           m_phase;
  logic         m_run;
  logic         m_tick;
  logic         m_wrap;
  logic [S:0]   m_hist;

  always @(posedge clk or negedge rst_n) begin : model
    int   c;
    int   ph;
    logic t;
    logic w;
    logic tog;
    if (!rst_n) begin
      m_count <= 0;
      m_phase <= 0;
      m_run   <= 1'b1;
      m_tick  <= 1'b0;
      m_wrap  <= 1'b0;
      m_hist  <= '0;
    end else begin
      c   = m_count;
      ph  = m_phase;
      t   = 1'b0;
      w   = 1'b0;
      // press seen S edges ago, released the edge before that
      tog = m_hist[S-1] & ~m_hist[S];
      if (clr) begin
        c  = 0;
        ph = 0;
      end else if (m_run) begin
        if (ph == P - 1) begin
          ph = 0;
          t  = 1'b1;
          if (dir) begin
            w = (c == MAXV);
            c = (c + 1) % (MAXV + 1);
          end else begin
            w = (c == 0);
            c = (c + MAXV) % (MAXV + 1);
          end
        end else begin
          ph = ph + 1;
        end
      end
      m_count <= c;
      m_phase <= ph;
      m_tick  <= t;
      m_wrap  <= w;
      m_run   <= tog ? ~m_run : m_run;
      m_hist  <= {m_hist[S-1:0], btn};
    end
  end

  // Every cycle out of reset the DUT must agree with the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_bcd",     32'(bcd),     32'(to_bcd(m_count)));
      check("model_tick",    32'(tick),    32'(m_tick));
      check("model_wrap",    32'(wrap),    32'(m_wrap));
      check("model_running", 32'(running), 32'(m_run));
    end
  end

  task automatic wait_tick(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (tick === 1'b1) return;
    end
    check("tick_timeout", 32'(tick), 32'd1);
  endtask

  task automatic ticks(input int n);
    int c;
    for (int i = 0; i < n; i++) wait_tick(c);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd",     32'(bcd),     32'h00);
    check("rst_running", 32'(running), 32'd1);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_wrap",    32'(wrap),    32'd0);
    rst_n = 1'b1;

    // Count up 1..10 with carry into digit 1
    wait_tick(c);
    check("first_tick_latency", c, 4);
    check("up_01", 32'(bcd), 32'h01);
    for (int k = 2; k <= 10; k++) begin
      wait_tick(c);
      check("tick_period", c, 4);
      check("up_seq", 32'(bcd), (k == 10) ? 32'h10 : 32'(k));
    end

    // Up to 99, then wrap to 00
    ticks(89);
    check("preload_99", 32'(bcd), 32'h99);
    wait_tick(c);
    check("wrap_up_bcd",  32'(bcd),  32'h00);
    check("wrap_up_wrap", 32'(wrap), 32'd1);
    @(negedge clk);
    check("wrap_one_cycle", 32'(wrap), 32'd0);
    check("tick_one_cycle", 32'(tick), 32'd0);

    // Count down: 00 -> 99 wraps, 99 -> 98 does not
    dir = 1'b0;
    wait_tick(c);
    check("wrap_dn_bcd",  32'(bcd),  32'h99);
    check("wrap_dn_wrap", 32'(wrap), 32'd1);
    wait_tick(c);
    check("dn_98_bcd",  32'(bcd),  32'h98);
    check("dn_98_wrap", 32'(wrap), 32'd0);

    // Up to 04, then press so the toggle lands on the step edge to 05
    dir = 1'b1;
    ticks(6);
    check("up_04", 32'(bcd), 32'h04);
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    check("press1_run_a", 32'(running), 32'd1);
    @(negedge clk);
    check("press1_run_b", 32'(running), 32'd1);
    @(negedge clk);
    check("press1_hold",     32'(running), 32'd0);
    check("press1_last_tick", 32'(tick),   32'd1);
    check("press1_bcd",      32'(bcd),     32'h05);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) btn = 1'b0;
      check("hold_bcd",  32'(bcd),  32'h05);
      check("hold_tick", 32'(tick), 32'd0);
    end

    // Second press resumes; full prescale period before 06
    btn = 1'b1;
    @(negedge clk);
    check("press2_hold_a", 32'(running), 32'd0);
    @(negedge clk);
    check("press2_hold_b", 32'(running), 32'd0);
    btn = 1'b0;
    @(negedge clk);
    check("press2_run", 32'(running), 32'd1);
    wait_tick(c);
    check("resume_latency", c, 4);
    check("resume_06", 32'(bcd), 32'h06);

    // CLR coincident with the step at 37
    ticks(31);
    check("up_37", 32'(bcd), 32'h37);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_bcd",  32'(bcd),  32'h00);
    check("clr_tick", 32'(tick), 32'd0);
    wait_tick(c);
    check("clr_latency", c, 4);
    check("clr_then_01", 32'(bcd), 32'h01);

    // Up to 42, enter HOLD, then asynchronous reset mid-cycle
    ticks(41);
    check("up_42", 32'(bcd), 32'h42);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    repeat (4) @(negedge clk);
    check("hold42_running", 32'(running), 32'd0);
    check("hold42_bcd",     32'(bcd),     32'h42);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bcd",     32'(bcd),     32'h00);
    check("async_rst_running", 32'(running), 32'd1);
    check("async_rst_tick",    32'(tick),    32'd0);
    check("async_rst_wrap",    32'(wrap),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_bcd", 32'(bcd), 32'h00);
    wait_tick(c);
    check("post_rst_latency", c, 4);
    check("post_rst_01", 32'(bcd), 32'h01);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
